// File: rtl/osd_overlay_mixer.sv
// Final OSD stage: delays video to meet the renderer's glyph flag, then blends the
// frame-latched OSD colour onto lit pixels with optional drop shadow and blinking.
module osd_overlay_mixer #(
  parameter int DELAY        = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_r,
  input  logic [7:0]  i_g,
  input  logic [7:0]  i_b,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic        osd_en,
  input  logic [23:0] osd_color,
  input  logic [1:0]  alpha,
  input  logic        shadow_en,
  input  logic        blink_en,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de
);

  localparam int PW = 27;
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [PW-1:0] dly [DELAY];
  logic [7:0]    v_r, v_g, v_b;
  logic          v_hs, v_vs, v_de;

  logic          vs_prev, en_d, blink_phase;
  logic [7:0]    blink_cnt;
  logic [23:0]   color_l, color_eff;
  logic [1:0]    alpha_l, alpha_eff;
  logic          shadow_l, shadow_eff;
  logic          frame_edge, hidden, lit, shade;
  logic [2:0]    w;
  logic [7:0]    mix_r, mix_g, mix_b;

  function automatic logic [7:0] blend(input logic [7:0] c, input logic [7:0] v,
                                       input logic [2:0] wt);
    logic [10:0] s;
    s = 11'(c) * 11'(wt) + 11'(v) * 11'(3'd4 - wt);
    return 8'(s >> 2);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) dly[i] <= '0;
    end else begin
      dly[0] <= {i_r, i_g, i_b, i_hs, i_vs, i_de};
      for (int i = 1; i < DELAY; i++) dly[i] <= dly[i-1];
    end
  end

  assign {v_r, v_g, v_b, v_hs, v_vs, v_de} = dly[DELAY-1];

  // The boundary pixel itself already mixes with the freshly sampled settings.
  always_comb begin
    frame_edge = vs_prev & ~v_vs;
    color_eff  = frame_edge ? osd_color : color_l;
    alpha_eff  = frame_edge ? alpha     : alpha_l;
    shadow_eff = frame_edge ? shadow_en : shadow_l;
    hidden     = blink_en & blink_phase;
    lit        = osd_en & v_de & ~hidden;
    shade      = shadow_eff & en_d & ~osd_en & v_de & ~hidden;
    case (alpha_eff)
      2'd0:    w = 3'd0;
      2'd1:    w = 3'd1;
      2'd2:    w = 3'd2;
      default: w = 3'd4;
    endcase
  end

  always_comb begin
    mix_r = v_r;
    mix_g = v_g;
    mix_b = v_b;
    if (!v_de) begin
      mix_r = '0;
      mix_g = '0;
      mix_b = '0;
    end else if (lit) begin
      mix_r = blend(color_eff[23:16], v_r, w);
      mix_g = blend(color_eff[15:8],  v_g, w);
      mix_b = blend(color_eff[7:0],   v_b, w);
    end else if (shade) begin
      mix_r = v_r >> 1;
      mix_g = v_g >> 1;
      mix_b = v_b >> 1;
    end
  end

  // Frame-rate state: settings latch and blink counter advance on the v_vs fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev     <= 1'b0;
      en_d        <= 1'b0;
      color_l     <= '0;
      alpha_l     <= '0;
      shadow_l    <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      vs_prev <= v_vs;
      en_d    <= osd_en & v_de;
      if (frame_edge) begin
        color_l  <= osd_color;
        alpha_l  <= alpha;
        shadow_l <= shadow_en;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_r  <= '0;
      o_g  <= '0;
      o_b  <= '0;
      o_hs <= 1'b0;
      o_vs <= 1'b0;
      o_de <= 1'b0;
    end else begin
      o_r  <= mix_r;
      o_g  <= mix_g;
      o_b  <= mix_b;
      o_hs <= v_hs;
      o_vs <= v_vs;
      o_de <= v_de;
    end
  end

endmodule
